test_sink: RTL
==============

Name: test_sink

Overview:
- Stream sink used by the processor and unit testbenches.
- Driven by the shared test clock/reset generator; sits directly downstream of the DUT's output val/rdy interface.
- Accepts messages, compares each in order against a preloaded expected-message table, and applies configurable backpressure.
- Reports done, sticky error, index of the first mismatch, and received count for the bench's CHECK_EQ checks.

Parameters:
- p_msg_nbits, 32: message width in bits.
- p_max_msgs, 32: depth of the expected-message table (power of 2, ≥ 2).
- p_delay, 0: stall cycles (recv_rdy low) inserted before each accept. 0 means rdy is held high back-to-back.

Ports:
- clk  input  1  test clock, shared with the clock/reset generator.
- rst  input  1  synchronous active-high reset.
- recv_val  input  1  upstream message valid.
- recv_rdy  output  1  sink ready.
- recv_msg  input  p_msg_nbits  upstream message.
- exp_wr_en  input  1  write strobe for the expected table.
- exp_wr_idx  input  $clog2(p_max_msgs)  table write index.
- exp_wr_msg  input  p_msg_nbits  expected message value.
- num_exp  input  $clog2(p_max_msgs)+1  number of messages to receive; held stable while rst is low.
- done  output  1  all num_exp messages received.
- error  output  1  sticky; set on any mismatch.
- err_idx  output  $clog2(p_max_msgs)  index of the first mismatch.
- recv_count  output  $clog2(p_max_msgs)+1  messages accepted so far.

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high, sampled on posedge clk.
- Reset values: recv_rdy=0, done=0, error=0, err_idx=0, recv_count=0.
  - Internal: idx=0, delay counter=p_delay, state=INIT.
  - The expected table is not cleared by reset.
- Table writes: occur on any posedge with exp_wr_en=1, including during reset.
  - A write to the entry being compared in the same cycle does not affect that cycle's comparison; the old value is used.
- Effective count: neff = min(num_exp, p_max_msgs).
- FSM states: INIT, WAIT, RECV, DONE.
  - INIT: lasts one cycle after rst deasserts. Next state is DONE if neff==0, else WAIT if p_delay>0, else RECV.
  - WAIT: recv_rdy=0. The delay counter decrements each cycle. When the counter is 1, go to RECV.
  - RECV: recv_rdy=1, combinational from state only; it never depends on recv_val.
  - Transfer: occurs on a posedge with recv_val && recv_rdy.
    - Compare recv_msg against exp[idx] using a 4-state inequality (!==).
    - On mismatch with error==0: set error=1 and err_idx=idx. Later mismatches do not change err_idx.
    - Then idx and recv_count increment.
    - If the new count equals neff, go to DONE. Otherwise reload the delay counter to p_delay and go to WAIT (p_delay>0) or stay in RECV (p_delay==0).
  - DONE: done=1, recv_rdy=0. Upstream messages are never consumed. Only rst leaves DONE.
- Latency:
  - With p_delay=0, recv_rdy rises the cycle after INIT and one message is accepted per cycle.
  - With p_delay=D, there are D stall cycles before each accept.
- recv_val low in RECV: remain in RECV; no counter changes.
- Reset mid-stream: reset has priority over transfer in the same cycle. All outputs return to reset values; table contents are preserved, so a rerun needs no reload.
- Arithmetic: idx wraps modulo p_max_msgs. This is unreachable because neff ≤ p_max_msgs.
- Timeout guard: none internally. A stalled DUT is caught by the bench cycle timeout.

Optional Feature:
- Macro: TEST_SINK_RAND_DELAY_EN.
- When defined:
  - Each reload of the delay counter uses a pseudo-random value in 0..p_delay instead of p_delay.
  - The value comes from a 32-bit Galois LFSR, polynomial 0x80200003, seeded to 32'hdeadbeef on reset.
  - The LFSR advances once per transfer. The delay is lfsr % (p_delay+1).
  - A reload value of 0 goes straight to RECV.
- When undefined: fixed delay exactly as specified above; no LFSR logic is present.

Test Plan:
- p_delay=0; load exp={0x11,0x22,0x33}, num_exp=3; source drives those values back-to-back → recv_rdy high from cycle 1 after INIT. Three accepts on consecutive cycles, done=1 the cycle after the third, error=0, recv_count=3.
- p_delay=2, same data → rdy pattern 0,0,1 per message. Each accept is 3 cycles apart; done after 9 cycles; error=0.
- Load exp={0xA,0xB,0xC,0xD}; source sends {0xA,0xF,0xC,0x0} → error=1 and err_idx=1, unchanged after the second mismatch at idx 3. done=1, recv_count=4.
- num_exp=0 → DONE right after INIT, done=1, recv_rdy never asserts, recv_count=0.
- p_delay=0, num_exp=4; recv_val toggles 1,0,0,1,1,0,1 → accepts only on val=1 cycles. recv_count steps 1,1,1,2,3,3,4, then done.
- Assert rst for one cycle after 2 of 4 messages → outputs clear, recv_count=0. Rerunning the same 4 messages without reloading the table gives done=1, error=0.

Source files
------------

// File: rtl/test_sink.sv
// test_sink: in-order stream checker with configurable backpressure.
// Accepts messages on a val/rdy interface, compares each one against a
// preloaded expected table, and reports done / sticky error / first
// mismatch index / received count.
// Optional feature macro: TEST_SINK_RAND_DELAY_EN (pseudo-random stall
// lengths in 0..p_delay drawn from a 32-bit Galois LFSR).
module test_sink #(
  parameter int p_msg_nbits = 32,
  parameter int p_max_msgs  = 32,
  parameter int p_delay     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          recv_val,
  output logic                          recv_rdy,
  input  logic [p_msg_nbits-1:0]        recv_msg,
  input  logic                          exp_wr_en,
  input  logic [$clog2(p_max_msgs)-1:0] exp_wr_idx,
  input  logic [p_msg_nbits-1:0]        exp_wr_msg,
  input  logic [$clog2(p_max_msgs):0]   num_exp,
  output logic                          done,
  output logic                          error,
  output logic [$clog2(p_max_msgs)-1:0] err_idx,
  output logic [$clog2(p_max_msgs):0]   recv_count
);

  localparam int IW = $clog2(p_max_msgs);
  localparam int CW = IW + 1;
  localparam int DW = (p_delay > 0) ? $clog2(p_delay + 1) : 1;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_WAIT = 2'd1,
    S_RECV = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [IW-1:0]          idx_r;
  logic [CW-1:0]          count_r;
  logic [DW-1:0]          dly_r;
  logic [DW-1:0]          dly_s;
  logic [DW-1:0]          reload_s;
  logic                   err_r;
  logic [IW-1:0]          eidx_r;
  logic                   rdy_r;
  logic                   done_r;
  logic                   xfer_s;
  logic                   mismatch_s;
  logic [CW-1:0]          neff_s;
  logic [p_msg_nbits-1:0] exp_mem [p_max_msgs];

`ifdef TEST_SINK_RAND_DELAY_EN
  logic [31:0] lfsr_r;
  logic [31:0] lfsr_nxt_s;

  // One right-shifting Galois step with taps 0x80200003.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
  endfunction
`endif

  // Effective message count is clamped to the table depth.
  assign neff_s = (num_exp > CW'(p_max_msgs)) ? CW'(p_max_msgs) : num_exp;

  assign recv_rdy   = rdy_r;
  assign done       = done_r;
  assign error      = err_r;
  assign err_idx    = eidx_r;
  assign recv_count = count_r;

  // Expected-table write port; not cleared by reset so reruns need no reload.
  always_ff @(posedge clk) begin
    if (exp_wr_en) begin
      exp_mem[exp_wr_idx] <= exp_wr_msg;
    end
  end

  // Stall reload value: fixed, or LFSR-derived when the random feature is on.
  always_comb begin
`ifdef TEST_SINK_RAND_DELAY_EN
    lfsr_nxt_s = lfsr_step(lfsr_r);
    reload_s   = DW'(lfsr_nxt_s % 32'(p_delay + 1));
`else
    reload_s   = DW'(p_delay);
`endif
  end

  // Next-state logic: INIT -> (WAIT|RECV|DONE), stall countdown, transfer.
  always_comb begin
    state_s    = state_r;
    dly_s      = dly_r;
    xfer_s     = rdy_r & recv_val;
    mismatch_s = (recv_msg !== exp_mem[idx_r]);
    case (state_r)
      S_INIT: begin
        if (neff_s == {CW{1'b0}}) begin
          state_s = S_DONE;
        end else if (dly_r != {DW{1'b0}}) begin
          state_s = S_WAIT;
        end else begin
          state_s = S_RECV;
        end
      end
      S_WAIT: begin
        dly_s = dly_r - DW'(1);
        if (dly_r <= DW'(1)) begin
          state_s = S_RECV;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_RECV: begin
        if (xfer_s) begin
          if ((count_r + CW'(1)) == neff_s) begin
            state_s = S_DONE;
          end else if (reload_s != {DW{1'b0}}) begin
            dly_s   = reload_s;
            state_s = S_WAIT;
          end else begin
            dly_s   = reload_s;
            state_s = S_RECV;
          end
        end else begin
          state_s = S_RECV;
        end
      end
      S_DONE: begin
        state_s = S_DONE;
      end
      default: begin
        state_s = S_INIT;
      end
    endcase
  end

  // State, counters and registered status outputs; reset wins over transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_INIT;
      idx_r   <= {IW{1'b0}};
      count_r <= {CW{1'b0}};
      dly_r   <= DW'(p_delay);
      err_r   <= 1'b0;
      eidx_r  <= {IW{1'b0}};
      rdy_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      dly_r   <= dly_s;
      rdy_r   <= (state_s == S_RECV);
      done_r  <= (state_s == S_DONE);
      if (xfer_s) begin
        idx_r   <= idx_r + IW'(1);
        count_r <= count_r + CW'(1);
        if (mismatch_s && !err_r) begin
          err_r  <= 1'b1;
          eidx_r <= idx_r;
        end
      end
    end
  end

`ifdef TEST_SINK_RAND_DELAY_EN
  // LFSR advances once per accepted message.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= 32'hdead_beef;
    end else if (xfer_s) begin
      lfsr_r <= lfsr_nxt_s;
    end
  end
`endif

endmodule
